// File: rtl/bip_run_ctrl_top_pkg.sv
// Shared definitions for the BIP run-control system.
//   run_state_e : run-control FSM state encoding (also the o_state output code)
//   OP_*        : instruction opcodes (upper NB_OPCODE bits of an instruction word)
//   default widths used by the top-level parameters
package bip_run_ctrl_top_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  localparam int OP_HLT  = 0;
  localparam int OP_STO  = 1;
  localparam int OP_LD   = 2;
  localparam int OP_LDI  = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_ADDI = 5;
  localparam int OP_SUB  = 6;
  localparam int OP_SUBI = 7;

  localparam int DEF_NB_INSTRUCTION = 16;
  localparam int DEF_NB_ADDR        = 11;
  localparam int DEF_NB_OPCODE      = 5;
  localparam int DEF_NB_CYCLES      = 32;

endpackage

// File: rtl/bip_run_ctrl_top_fsm.sv
// Run-control FSM: command decode, core enable / soft reset and the
// executed-cycle counter.
//   clk, rst         : clock, asynchronous active-high reset
//   cmd_run/step/halt: one-cycle host command pulses (halt > step > run)
//   program_done     : cpu is executing HLT this cycle
//   state            : current run state
//   core_en          : cpu clock enable (RUN and STEP)
//   core_rst         : registered cpu soft reset, high while IDLE
//   load_ready       : program-load port may write (IDLE only)
//   cycle_count      : saturating count of enabled cycles since leaving IDLE
module bip_run_ctrl_top_fsm
  import bip_run_ctrl_top_pkg::*;
#(
  parameter int NB_CYCLES = DEF_NB_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_run,
  input  logic                 cmd_step,
  input  logic                 cmd_halt,
  input  logic                 program_done,
  output run_state_e           state,
  output logic                 core_en,
  output logic                 core_rst,
  output logic                 load_ready,
  output logic [NB_CYCLES-1:0] cycle_count
);

  run_state_e state_d;

  function automatic logic [NB_CYCLES-1:0] sat_inc(input logic [NB_CYCLES-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // state register; core_rst follows the next state so the cpu is
  // cleared at the same edge the FSM lands in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      core_rst <= 1'b1;
    end else begin
      state    <= state_d;
      core_rst <= (state_d == ST_IDLE);
    end
  end

  // next-state decode
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (cmd_step)     state_d = ST_STEP;
        else if (cmd_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        // a HLT executed this cycle beats a same-cycle halt command
        if (program_done)  state_d = ST_DONE;
        else if (cmd_halt) state_d = ST_PAUSE;
      end
      ST_STEP:  state_d = program_done ? ST_DONE : ST_PAUSE;
      ST_PAUSE: begin
        if (cmd_halt)      state_d = ST_IDLE;
        else if (cmd_step) state_d = ST_STEP;
        else if (cmd_run)  state_d = ST_RUN;
      end
      ST_DONE: begin
        if (cmd_halt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    core_en    = (state == ST_RUN) || (state == ST_STEP);
    load_ready = (state == ST_IDLE);
  end

  // executed-cycle counter, cleared on the way into IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cycle_count <= '0;
    else if (state_d == ST_IDLE) cycle_count <= '0;
    else if (core_en)           cycle_count <= sat_inc(cycle_count);
  end

endmodule

// File: rtl/bip_run_ctrl_top.sv
// BIP system top: accumulator cpu, writable program RAM, data RAM and
// run-control FSM.
//   i_clock, i_reset     : clock, asynchronous active-high reset
//   i_load_valid/addr/data, o_load_ready : program-word write port (IDLE only)
//   i_cmd_run/step/halt  : host command pulses
//   o_state              : IDLE=0 RUN=1 STEP=2 PAUSE=3 DONE=4
//   o_accumulator        : cpu accumulator
//   o_program_counter    : cpu program counter
//   o_program_done       : high while DONE
//   o_cycle_count        : enabled cycles since leaving IDLE (saturating)
module bip_run_ctrl_top
  import bip_run_ctrl_top_pkg::*;
#(
  parameter int NB_INSTRUCTION = DEF_NB_INSTRUCTION,
  parameter int NB_ADDR        = DEF_NB_ADDR,
  parameter int NB_OPCODE      = DEF_NB_OPCODE,
  parameter int NB_CYCLES      = DEF_NB_CYCLES
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_load_valid,
  input  logic [NB_ADDR-1:0]        i_load_addr,
  input  logic [NB_INSTRUCTION-1:0] i_load_data,
  output logic                      o_load_ready,
  input  logic                      i_cmd_run,
  input  logic                      i_cmd_step,
  input  logic                      i_cmd_halt,
  output logic [2:0]                o_state,
  output logic [NB_INSTRUCTION-1:0] o_accumulator,
  output logic [NB_ADDR-1:0]        o_program_counter,
  output logic                      o_program_done,
  output logic [NB_CYCLES-1:0]      o_cycle_count
);

  localparam int NB_OPERAND = NB_INSTRUCTION - NB_OPCODE;
  localparam int DEPTH      = 2 ** NB_ADDR;

  run_state_e                       state;
  logic                             core_en;
  logic                             core_rst;
  logic                             cpu_rst;
  logic                             program_done;

  logic        [NB_INSTRUCTION-1:0] pmem [DEPTH];
  logic signed [NB_INSTRUCTION-1:0] dmem [DEPTH];

  logic        [NB_ADDR-1:0]        pc;
  logic signed [NB_INSTRUCTION-1:0] acc;
  logic        [NB_INSTRUCTION-1:0] instr;
  logic        [NB_OPCODE-1:0]      opcode;
  logic        [NB_OPERAND-1:0]     operand;
  logic signed [NB_INSTRUCTION-1:0] imm;
  logic        [NB_ADDR-1:0]        dmem_addr;
  logic signed [NB_INSTRUCTION-1:0] dmem_rd;
  logic                             dmem_we;

  bip_run_ctrl_top_fsm #(
    .NB_CYCLES (NB_CYCLES)
  ) u_fsm (
    .clk          (i_clock),
    .rst          (i_reset),
    .cmd_run      (i_cmd_run),
    .cmd_step     (i_cmd_step),
    .cmd_halt     (i_cmd_halt),
    .program_done (program_done),
    .state        (state),
    .core_en      (core_en),
    .core_rst     (core_rst),
    .load_ready   (o_load_ready),
    .cycle_count  (o_cycle_count)
  );

  // program RAM: load write port, combinational cpu fetch port
  always_ff @(posedge i_clock) begin
    if (i_load_valid && o_load_ready) pmem[i_load_addr] <= i_load_data;
  end

  assign instr        = pmem[pc];
  assign opcode       = instr[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign operand      = instr[NB_OPERAND-1:0];
  assign imm          = {{NB_OPCODE{operand[NB_OPERAND-1]}}, operand};
  assign program_done = (opcode == NB_OPCODE'(OP_HLT));

  // data RAM: one shared address, combinational read, synchronous write
  assign dmem_addr = operand[NB_ADDR-1:0];
  assign dmem_rd   = dmem[dmem_addr];
  assign dmem_we   = core_en && (opcode == NB_OPCODE'(OP_STO));

  always_ff @(posedge i_clock) begin
    if (dmem_we) dmem[dmem_addr] <= acc;
  end

  // cpu: one instruction per enabled cycle; HLT holds the PC on itself
  assign cpu_rst = i_reset | core_rst;

  always_ff @(posedge i_clock or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc  <= '0;
      acc <= '0;
    end else if (core_en) begin
      if (!program_done) pc <= pc + 1'b1;
      case (opcode)
        NB_OPCODE'(OP_LD):   acc <= dmem_rd;
        NB_OPCODE'(OP_LDI):  acc <= imm;
        NB_OPCODE'(OP_ADD):  acc <= acc + dmem_rd;
        NB_OPCODE'(OP_ADDI): acc <= acc + imm;
        NB_OPCODE'(OP_SUB):  acc <= acc - dmem_rd;
        NB_OPCODE'(OP_SUBI): acc <= acc - imm;
        default: ;
      endcase
    end
  end

  assign o_state           = state;
  assign o_accumulator     = acc;
  assign o_program_counter = pc;
  assign o_program_done    = (state == ST_DONE);

endmodule

// File: tb/tb_bip_run_ctrl_top.sv
module tb_bip_run_ctrl_top;

  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_PAUSE = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [10:0] load_addr;
  logic [15:0] load_data;
  logic        cmd_run, cmd_step, cmd_halt;

  logic        ready, done;
  logic [2:0]  state;
  logic [15:0] acc;
  logic [10:0] pc;
  logic [31:0] cnt;

  logic        ready4, done4;
  logic [2:0]  state4;
  logic [15:0] acc4;
  logic [10:0] pc4;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: architectural view of the system
  int          m_state;
  logic [10:0] m_pc;
  logic [15:0] m_acc;
  longint      m_cnt;
  logic [15:0] m_pmem [2048];
  logic [15:0] m_dmem [2048];

  always #5 clk = ~clk;

  bip_run_ctrl_top u_dut (
    .i_clock(clk), .i_reset(rst),
    .i_load_valid(load_valid), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_load_ready(ready),
    .i_cmd_run(cmd_run), .i_cmd_step(cmd_step), .i_cmd_halt(cmd_halt),
    .o_state(state), .o_accumulator(acc), .o_program_counter(pc),
    .o_program_done(done), .o_cycle_count(cnt)
  );

  bip_run_ctrl_top #(.NB_CYCLES(4)) u_sat (
    .i_clock(clk), .i_reset(rst),
    .i_load_valid(load_valid), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_load_ready(ready4),
    .i_cmd_run(cmd_run), .i_cmd_step(cmd_step), .i_cmd_halt(cmd_halt),
    .o_state(state4), .o_accumulator(acc4), .o_program_counter(pc4),
    .o_program_done(done4), .o_cycle_count(cnt4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_pc = '0; m_acc = '0; m_cnt = 0;
  endtask

  // execute the instruction at m_pc; returns 1 for HLT
  task automatic model_exec(output bit hlt);
    logic [15:0] ins;
    logic [10:0] opd;
    logic [15:0] imm;
    int op;
    ins = m_pmem[m_pc];
    op  = int'(ins[15:11]);
    opd = ins[10:0];
    imm = {{5{opd[10]}}, opd};
    hlt = (op == 0);
    case (op)
      1: m_dmem[opd] = m_acc;
      2: m_acc = m_dmem[opd];
      3: m_acc = imm;
      4: m_acc = m_acc + m_dmem[opd];
      5: m_acc = m_acc + imm;
      6: m_acc = m_acc - m_dmem[opd];
      7: m_acc = m_acc - imm;
      default: ;
    endcase
    if (!hlt) m_pc = m_pc + 11'd1;
  endtask

  task automatic model_edge();
    int nxt;
    bit hlt;
    nxt = m_state;
    case (m_state)
      S_IDLE: begin
        if (load_valid) m_pmem[load_addr] = load_data;
        if (cmd_step) nxt = S_STEP;
        else if (cmd_run) nxt = S_RUN;
      end
      S_RUN, S_STEP: begin
        model_exec(hlt);
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (hlt) nxt = S_DONE;
        else if (m_state == S_STEP || cmd_halt) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (cmd_halt) nxt = S_IDLE;
        else if (cmd_step) nxt = S_STEP;
        else if (cmd_run) nxt = S_RUN;
      end
      S_DONE: if (cmd_halt) nxt = S_IDLE;
      default: ;
    endcase
    m_state = nxt;
    if (m_state == S_IDLE) begin m_pc = '0; m_acc = '0; m_cnt = 0; end
  endtask

  task automatic compare_model();
    chk("state", 64'(state), 64'(m_state));
    chk("pc", 64'(pc), 64'(m_pc));
    chk("acc", 64'(acc), 64'(m_acc));
    chk("cycle_count", 64'(cnt), 64'(m_cnt));
    chk("load_ready", 64'(ready), 64'(m_state == S_IDLE));
    chk("program_done", 64'(done), 64'(m_state == S_DONE));
    chk("sat_state", 64'(state4), 64'(m_state));
    chk("sat_count", 64'(cnt4), 64'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  // one clock: drive at negedge, model at posedge, check at next negedge
  task automatic cycle(input bit r, input bit s, input bit h,
                       input bit lv = 1'b0, input logic [10:0] la = '0,
                       input logic [15:0] ld = '0);
    cmd_run = r; cmd_step = s; cmd_halt = h;
    load_valid = lv; load_addr = la; load_data = ld;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmd_run = 0; cmd_step = 0; cmd_halt = 0; load_valid = 0;
    compare_model();
  endtask

  task automatic load_word(input logic [10:0] a, input logic [15:0] d);
    cycle(0, 0, 0, 1'b1, a, d);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 4 && m_state != S_IDLE; i++) cycle(0, 0, 1);
  endtask

  typedef struct {
    bit r, s, h, lv;
    logic [10:0] la;
    logic [15:0] ld;
    int e_state;
    int e_pc;
    int e_acc;
    int e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, s, h, lv, input int la, ld, es, epc, eacc, ecnt);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.lv = lv; v.la = 11'(la); v.ld = 16'(ld);
    v.e_state = es; v.e_pc = epc; v.e_acc = eacc; v.e_cnt = ecnt;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] prog [$];
    int len;
    rst = 1; load_valid = 0; load_addr = '0; load_data = '0;
    cmd_run = 0; cmd_step = 0; cmd_halt = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare_model();
    rst = 0;
    @(negedge clk);
    compare_model();

    // directed table: load + run to DONE, then single-step the same program
    add(0,0,0,1, 0,16'h1805, S_IDLE,0,0,0);
    add(0,0,0,1, 1,16'h2803, S_IDLE,0,0,0);
    add(0,0,0,1, 2,16'h0800, S_IDLE,0,0,0);
    add(0,0,0,1, 3,16'h0000, S_IDLE,0,0,0);
    add(1,0,0,0, 0,0, S_RUN,0,0,0);
    add(0,0,0,0, 0,0, S_RUN,1,5,1);
    add(0,0,0,0, 0,0, S_RUN,2,8,2);
    add(0,0,0,0, 0,0, S_RUN,3,8,3);
    add(0,0,0,0, 0,0, S_DONE,3,8,4);
    add(1,0,0,0, 0,0, S_DONE,3,8,4);
    add(0,1,0,0, 0,0, S_DONE,3,8,4);
    add(0,0,1,0, 0,0, S_IDLE,0,0,0);
    add(0,1,0,0, 0,0, S_STEP,0,0,0);
    add(0,0,0,0, 0,0, S_PAUSE,1,5,1);
    add(0,0,0,0, 0,0, S_PAUSE,1,5,1);
    add(0,1,0,0, 0,0, S_STEP,1,5,1);
    add(0,0,0,0, 0,0, S_PAUSE,2,8,2);
    add(0,1,0,0, 0,0, S_STEP,2,8,2);
    add(0,0,0,0, 0,0, S_PAUSE,3,8,3);
    add(0,1,0,0, 0,0, S_STEP,3,8,3);
    add(0,0,0,0, 0,0, S_DONE,3,8,4);
    add(0,0,1,0, 0,0, S_IDLE,0,0,0);
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].lv, tbl[i].la, tbl[i].ld);
      chk($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].e_state));
      chk($sformatf("tbl%0d_pc", i), 64'(pc), 64'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_acc", i), 64'(acc), 64'(tbl[i].e_acc));
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].e_cnt));
    end
    chk("dmem0_after_sto", 64'(u_dut.dmem[0]), 64'd8);

    // non-halting loop: pause after 10 cycles, abort, then saturation
    load_word(0, 16'h1801);
    for (int a = 1; a < 32; a++) load_word(11'(a), 16'h2801);
    cycle(1, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("loop_pause_state", 64'(state), 64'(S_PAUSE));
    chk("loop_pause_cnt", 64'(cnt), 64'd10);
    chk("loop_pause_acc", 64'(acc), 64'd10);
    cycle(0, 0, 1);
    chk("loop_abort_state", 64'(state), 64'(S_IDLE));
    chk("loop_abort_pc", 64'(pc), 64'd0);
    chk("loop_abort_cnt", 64'(cnt), 64'd0);
    cycle(1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0);
    chk("sat4_count", 64'(cnt4), 64'd15);
    chk("sat_main_count", 64'(cnt), 64'd20);
    go_idle();

    // reset in the middle of RUN, then rerun the same program
    load_word(0, 16'h1805); load_word(1, 16'h2803);
    load_word(2, 16'h0800); load_word(3, 16'h0000);
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    rst = 1;
    #1;
    model_reset();
    chk("rst_state", 64'(state), 64'(S_IDLE));
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 0;
    compare_model();
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    chk("rerun_state", 64'(state), 64'(S_DONE));
    chk("rerun_acc", 64'(acc), 64'd8);
    chk("rerun_cnt", 64'(cnt), 64'd4);
    go_idle();

    // load ignored while running; all three commands at once pause
    load_word(0, 16'h1801); load_word(1, 16'h2801);
    load_word(2, 16'h2801); load_word(3, 16'h2801);
    cycle(1, 0, 0);
    cycle(0, 0, 0, 1'b1, 11'd2, 16'h0000);
    chk("run_load_ready", 64'(ready), 64'd0);
    chk("run_load_pmem2", 64'(u_dut.pmem[2]), 64'h2801);
    cycle(1, 1, 1);
    chk("all_cmds_state", 64'(state), 64'(S_PAUSE));
    go_idle();

    // randomized programs against the model
    for (int p = 0; p < 30; p++) begin
      go_idle();
      prog.delete();
      prog.push_back(16'h1800);
      for (int a = 0; a < 8; a++) prog.push_back({5'd1, 11'(a)});
      len = $urandom_range(5, 20);
      for (int i = 0; i < len; i++) begin
        int k;
        logic [4:0] op;
        logic [10:0] opd;
        k = $urandom_range(0, 7);
        op = (k == 7) ? 5'd9 : 5'(k + 1);
        opd = (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6)
              ? 11'($urandom_range(0, 7)) : 11'($urandom_range(0, 2047));
        prog.push_back({op, opd});
      end
      prog.push_back(16'h0000);
      foreach (prog[i]) load_word(11'(i), prog[i]);
      for (int c = 0; c < 60; c++) begin
        bit lv;
        logic [10:0] la;
        lv = ($urandom_range(0, 7) == 0);
        la = 11'($urandom_range(9, prog.size() - 2));
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0, lv, la,
              {5'd5, 11'($urandom_range(0, 2047))});
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
